laser_search_ctrl: RTL and testbench
====================================

# laser_search_ctrl

Sequencing controller for the LASER two-circle coverage engine. It owns the point-load window, raster-scans candidate centres over the 16×16 grid, and drives a separate coverage evaluator through a request/acknowledge handshake. It alternately re-optimises C1 and C2 by coordinate descent, and publishes C1X/C1Y/C2X/C2Y with a one-cycle DONE pulse.

## Interface

**Parameters**
- `NPTS`, 40: points per pattern.
- `PH_MAX`, 8: maximum optimisation phases per pattern (≥2).

**Ports** (name, direction, width, meaning)
- `CLK`, in, 1: single clock, rising edge.
- `RST`, in, 1: reset is synchronous and active-low.
- `LD_EN`, out, 1: evaluator captures X/Y into slot `LD_IDX` this cycle.
- `LD_IDX`, out, 6: point slot index, 0..NPTS-1.
- `EV_REQ`, out, 1: evaluation request.
- `EV_CX`, `EV_CY`, out, 4 each: candidate centre.
- `EV_FEN`, out, 1: fixed circle valid; when 0, evaluator counts candidate coverage only.
- `EV_FX`, `EV_FY`, out, 4 each: fixed (other) circle centre.
- `EV_ACK`, in, 1: evaluation complete; `EV_CNT` valid this cycle.
- `EV_CNT`, in, 6: points within distance² ≤ 16 of candidate OR fixed circle.
- `C1X`, `C1Y`, `C2X`, `C2Y`, out, 4 each: committed centres.
- `DONE`, out, 1: result valid pulse.

## Operation

- **States:** LOAD, SCAN, COMMIT, FINISH.
- **Reset** (RST low at a clock edge, any state):
  - state := LOAD, LD_IDX := 0.
  - All outputs 0, except LD_EN = 1 on the first post-reset cycle.
  - phase := 0, cur_total := 0.
  - Any in-flight evaluation is abandoned; a late EV_ACK is ignored.
- **LOAD:**
  - LD_EN = 1 for exactly NPTS consecutive cycles, LD_IDX = 0..NPTS-1.
  - After LD_IDX = NPTS-1, go to SCAN with the candidate at (0,0).
- **SCAN:**
  - Raster order: cy outer, cx inner, 0..15 each, giving 256 candidates.
  - Phase parity:
    - Even phase: the candidate replaces C1 and the fixed circle is C2.
    - Odd phase: the candidate replaces C2 and the fixed circle is C1.
  - Phase 0 drives EV_FEN = 0; all later phases drive EV_FEN = 1.
  - Track phase_best and its position. Update only when EV_CNT > phase_best (strict), so the first candidate in raster order wins ties.
  - After the ACK for candidate (15,15), go to COMMIT.
- **COMMIT** (1 cycle):
  - If phase_best > cur_total: write the winner to the phase's circle, set cur_total := phase_best, clear stall.
  - Otherwise: stall := stall+1.
  - phase := phase+1.
  - If stall = 2 or phase = PH_MAX, go to FINISH; otherwise return to SCAN at (0,0).
- **FINISH:**
  - DONE = 1 for one cycle, then LOAD with LD_IDX = 0 on the next cycle.
  - C1X..C2Y hold their values until a later COMMIT changes them or reset clears them.
- **Width rules:**
  - phase_best and cur_total are 6 bits.
  - The candidate counter is 8 bits ({cy,cx}) and wraps 255→0 only on phase change.
  - EV_CNT > NPTS is treated as NPTS (saturating compare).

## Timing

- **Handshake:** valid/ack.
  - EV_REQ rises the first SCAN cycle.
  - While EV_REQ = 1 and EV_ACK = 0, all EV_* fields stay stable.
  - EV_ACK may be high in the same cycle EV_REQ rises (zero-wait evaluator).
  - On an ACK cycle, the next candidate's fields appear the following cycle and EV_REQ stays high, so the best case is one evaluation per cycle.
  - After the final ACK of a phase, EV_REQ is low through COMMIT.
- **Stray ACK:** EV_ACK while EV_REQ = 0 is ignored.
- **Phase latency:** 256 × (evaluator wait + 1) cycles, plus 1 COMMIT cycle.
- **Pattern latency:** NPTS load cycles + phases × phase latency + 1 FINISH cycle.
- **Phase-count bounds:** best case (zero-wait evaluator, early convergence) is 3 phases; worst case is PH_MAX phases.
- **Output update:** C1X..C2Y change only on the edge that leaves COMMIT. DONE rises on the edge entering FINISH.

## Structure

- Shared package `laser_pkg` holds:
  - state enum `laser_st_t` (LOAD/SCAN/COMMIT/FINISH);
  - `GRID = 16`, `RADIUS_SQ = 16`, `NPTS_DEF = 40`;
  - coordinate typedef `coord_t` (4 bits);
  - count typedef `cnt_t` (6 bits).
- One sub-module, `laser_cand_gen`: an 8-bit raster counter with `clr`/`adv` inputs and `cx`/`cy`/`last` outputs.
- FSM, best tracking and commit logic live in the top module.

## Test plan

- **Load window:** reset held low 2 cycles, then released → LD_EN high for exactly 40 cycles with LD_IDX 0→39, EV_REQ first high on cycle 41.
- **Zero-wait evaluator, constant EV_CNT = 5:**
  - Phase 0 commits C1 = (0,0) with cur_total 5.
  - Phases 1 and 2 make no improvement → DONE after phase 2, outputs C1 = (0,0), C2 = (0,0).
- **Model evaluator on the img1 point set (4-cycle ACK wait):** result coverage equals a reference coordinate-descent model; EV fields stable across every wait cycle.
- **Tie rule:** evaluator returns 12 at (3,4) and at (9,9), less elsewhere in phase 0 → C1 = (3,4).
- **PH_MAX:** evaluator returns a strictly rising count every phase, with PH_MAX = 4 → DONE after exactly 4 COMMITs, then LD_EN asserted the next cycle.
- **Reset mid-SCAN:** RST low during a pending request → next cycle EV_REQ = 0, outputs 0, LD_IDX = 0; an ACK arriving during reset has no effect.

Source files
------------

// File: rtl/laser_pkg.sv
// Shared types and constants for the LASER two-circle coverage search engine.
package laser_pkg;

    localparam int GRID      = 16;
    localparam int RADIUS_SQ = 16;
    localparam int NPTS_DEF  = 40;

    typedef logic [3:0] coord_t;
    typedef logic [5:0] cnt_t;

    typedef enum logic [1:0] {
        LOAD,
        SCAN,
        COMMIT,
        FINISH
    } laser_st_t;

    // Clamp an evaluator count so out-of-range reports cannot beat a full cover.
    function automatic cnt_t satCnt(input cnt_t value, input cnt_t limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/laser_cand_gen.sv
// Raster candidate generator: {cy,cx} counter that steps on each accepted evaluation.
module laser_cand_gen
    import laser_pkg::*;
(
    input  logic   i_clk,
    input  logic   i_rstN,
    input  logic   i_clr,
    input  logic   i_adv,
    output coord_t o_cx,
    output coord_t o_cy,
    output logic   o_last
);

    localparam logic [7:0] CNT_LAST = 8'(GRID * GRID - 1);

    logic [7:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rstN || i_clr) begin
            r_cnt <= '0;
        end else if (i_adv) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_cx   = r_cnt[3:0];
    assign o_cy   = r_cnt[7:4];
    assign o_last = (r_cnt == CNT_LAST);

endmodule

// File: rtl/laser_search_ctrl.sv
// Sequencer for the two-circle coverage search: point load, raster scan per phase,
// alternating coordinate descent on C1/C2, and result publication with a DONE pulse.
module laser_search_ctrl
    import laser_pkg::*;
#(
    parameter int NPTS   = NPTS_DEF,
    parameter int PH_MAX = 8
) (
    input  logic       CLK,
    input  logic       RST,
    output logic       LD_EN,
    output logic [5:0] LD_IDX,
    output logic       EV_REQ,
    output logic [3:0] EV_CX,
    output logic [3:0] EV_CY,
    output logic       EV_FEN,
    output logic [3:0] EV_FX,
    output logic [3:0] EV_FY,
    input  logic       EV_ACK,
    input  logic [5:0] EV_CNT,
    output logic [3:0] C1X,
    output logic [3:0] C1Y,
    output logic [3:0] C2X,
    output logic [3:0] C2Y,
    output logic       DONE
);

    localparam cnt_t       LD_LAST = cnt_t'(NPTS - 1);
    localparam cnt_t       CNT_MAX = cnt_t'(NPTS);
    localparam logic [7:0] PH_END  = 8'(PH_MAX);

    laser_st_t  r_state;
    laser_st_t  w_nextState;
    cnt_t       r_ldIdx;
    logic [7:0] r_phase;
    logic [1:0] r_stall;
    cnt_t       r_curTotal;
    cnt_t       r_phaseBest;
    coord_t     r_bestX;
    coord_t     r_bestY;
    coord_t     r_c1x;
    coord_t     r_c1y;
    coord_t     r_c2x;
    coord_t     r_c2y;

    coord_t     w_cx;
    coord_t     w_cy;
    logic       w_last;
    logic       w_inScan;
    logic       w_scanAck;
    logic       w_evenPhase;
    cnt_t       w_cntSat;
    logic       w_improve;
    logic [1:0] w_stallNext;
    logic [7:0] w_phaseNext;
    logic       w_finish;

    assign w_inScan    = (r_state == SCAN);
    assign w_scanAck   = w_inScan && EV_ACK;
    assign w_evenPhase = ~r_phase[0];
    assign w_cntSat    = satCnt(EV_CNT, CNT_MAX);
    assign w_improve   = (r_phaseBest > r_curTotal);
    assign w_stallNext = w_improve ? 2'd0 : (r_stall + 2'd1);
    assign w_phaseNext = r_phase + 8'd1;
    assign w_finish    = (w_stallNext == 2'd2) || (w_phaseNext == PH_END);

    // The counter is held at (0,0) outside SCAN, so every phase restarts the raster.
    laser_cand_gen u_candGen (
        .i_clk  (CLK),
        .i_rstN (RST),
        .i_clr  (!w_inScan),
        .i_adv  (w_scanAck && !w_last),
        .o_cx   (w_cx),
        .o_cy   (w_cy),
        .o_last (w_last)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            LOAD:    if (r_ldIdx == LD_LAST) w_nextState = SCAN;
            SCAN:    if (w_scanAck && w_last) w_nextState = COMMIT;
            COMMIT:  w_nextState = w_finish ? FINISH : SCAN;
            FINISH:  w_nextState = LOAD;
            default: w_nextState = LOAD;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST || (r_state != LOAD)) begin
            r_ldIdx <= '0;
        end else if (r_ldIdx != LD_LAST) begin
            r_ldIdx <= r_ldIdx + cnt_t'(1);
        end
    end

    // Strict compare keeps the earliest raster position on equal counts.
    always_ff @(posedge CLK) begin
        if (!RST || !w_inScan) begin
            r_phaseBest <= '0;
            r_bestX     <= '0;
            r_bestY     <= '0;
        end else if (w_scanAck && (w_cntSat > r_phaseBest)) begin
            r_phaseBest <= w_cntSat;
            r_bestX     <= w_cx;
            r_bestY     <= w_cy;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_phase    <= '0;
            r_stall    <= '0;
            r_curTotal <= '0;
            r_c1x      <= '0;
            r_c1y      <= '0;
            r_c2x      <= '0;
            r_c2y      <= '0;
        end else if (r_state == COMMIT) begin
            r_phase <= w_phaseNext;
            r_stall <= w_stallNext;
            if (w_improve) begin
                r_curTotal <= r_phaseBest;
                if (w_evenPhase) begin
                    r_c1x <= r_bestX;
                    r_c1y <= r_bestY;
                end else begin
                    r_c2x <= r_bestX;
                    r_c2y <= r_bestY;
                end
            end
        end else if (r_state == FINISH) begin
            r_phase    <= '0;
            r_stall    <= '0;
            r_curTotal <= '0;
        end
    end

    assign LD_EN  = (r_state == LOAD);
    assign LD_IDX = r_ldIdx;
    assign EV_REQ = w_inScan;
    assign EV_CX  = w_inScan ? w_cx : '0;
    assign EV_CY  = w_inScan ? w_cy : '0;
    assign EV_FEN = w_inScan && (r_phase != 8'd0);
    assign EV_FX  = !w_inScan ? '0 : (w_evenPhase ? r_c2x : r_c1x);
    assign EV_FY  = !w_inScan ? '0 : (w_evenPhase ? r_c2y : r_c1y);
    assign DONE   = (r_state == FINISH);
    assign C1X    = r_c1x;
    assign C1Y    = r_c1y;
    assign C2X    = r_c2x;
    assign C2Y    = r_c2y;

endmodule

// File: tb/tb_laser_search_ctrl.sv
// Directed bench for laser_search_ctrl: a behavioural evaluator answers requests with
// mode-selected counts; final centres, latencies and handshake behaviour are checked.
module tb_laser_search_ctrl;
    import laser_pkg::*;

    localparam int TB_NPTS   = 40;
    localparam int TB_PH_MAX = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       EV_ACK = 1'b0;
    logic [5:0] EV_CNT = '0;
    logic       LD_EN, EV_REQ, EV_FEN, DONE;
    logic [5:0] LD_IDX;
    logic [3:0] EV_CX, EV_CY, EV_FX, EV_FY, C1X, C1Y, C2X, C2Y;

    int checks = 0;
    int errors = 0;

    int evMode = 0;
    int evWait = 0;
    bit evForce = 1'b0;
    int evalCount = 0;
    int stableErr = 0;
    int orderErr = 0;
    int fenSeen[8];
    int fxSeen[8];
    int fySeen[8];
    int ptX[TB_NPTS];
    int ptY[TB_NPTS];

    always #5 CLK = ~CLK;

    laser_search_ctrl #(.NPTS(TB_NPTS), .PH_MAX(TB_PH_MAX)) dut (
        .CLK(CLK), .RST(RST), .LD_EN(LD_EN), .LD_IDX(LD_IDX),
        .EV_REQ(EV_REQ), .EV_CX(EV_CX), .EV_CY(EV_CY), .EV_FEN(EV_FEN),
        .EV_FX(EV_FX), .EV_FY(EV_FY), .EV_ACK(EV_ACK), .EV_CNT(EV_CNT),
        .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y), .DONE(DONE)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    function automatic int coverCnt(input int cx, input int cy, input bit fen, input int fx, input int fy);
        int n = 0;
        for (int i = 0; i < TB_NPTS; i++) begin
            int dc = (ptX[i] - cx) * (ptX[i] - cx) + (ptY[i] - cy) * (ptY[i] - cy);
            int df = (ptX[i] - fx) * (ptX[i] - fx) + (ptY[i] - fy) * (ptY[i] - fy);
            if (dc <= RADIUS_SQ || (fen && df <= RADIUS_SQ)) n++;
        end
        return n;
    endfunction

    // Mode 2 places a saturating 63 after a 40 to exercise the clamp; mode 3 rises each phase.
    function automatic int modeCnt(input int p, input int cx, input int cy, input bit fen, input int fx, input int fy);
        case (evMode)
            1: return coverCnt(cx, cy, fen, fx, fy);
            2: begin
                if (p == 0) return ((cx == 3 && cy == 4) || (cx == 9 && cy == 9)) ? 12 : 7;
                if (p == 1) return (cx == 6 && cy == 2) ? 40 : ((cx == 11 && cy == 5) ? 63 : 7);
                return 7;
            end
            3: begin
                int tx, ty;
                case (p)
                    0: begin tx = 2;  ty = 3;  end
                    1: begin tx = 7;  ty = 1;  end
                    2: begin tx = 10; ty = 12; end
                    default: begin tx = 5; ty = 14; end
                endcase
                return p * 5 + ((cx == tx && cy == ty) ? 4 : 1);
            end
            default: return 5;
        endcase
    endfunction

    // Behavioural evaluator: answers after evWait idle cycles and polices field stability.
    initial begin
        int wc = 0;
        bit pending = 1'b0;
        logic [16:0] held = '0;
        logic [16:0] cur;
        int p;
        forever begin
            @(negedge CLK);
            if (LD_EN === 1'b1) evalCount = 0;
            if (evForce) begin
                EV_ACK = 1'b1;
                pending = 1'b0;
                wc = 0;
            end else if (EV_REQ === 1'b1) begin
                cur = {EV_CX, EV_CY, EV_FEN, EV_FX, EV_FY};
                if (pending && cur !== held) stableErr++;
                held = cur;
                if (wc == evWait) begin
                    p = evalCount / 256;
                    if (int'(EV_CX) != evalCount % 16 || int'(EV_CY) != (evalCount / 16) % 16) orderErr++;
                    if (evalCount % 256 == 0 && p < 8) begin
                        fenSeen[p] = int'(EV_FEN);
                        fxSeen[p]  = int'(EV_FX);
                        fySeen[p]  = int'(EV_FY);
                    end
                    EV_CNT = 6'(modeCnt(p, int'(EV_CX), int'(EV_CY), EV_FEN, int'(EV_FX), int'(EV_FY)));
                    EV_ACK = 1'b1;
                    evalCount++;
                    wc = 0;
                    pending = 1'b0;
                end else begin
                    EV_ACK = 1'b0;
                    wc++;
                    pending = 1'b1;
                end
            end else begin
                EV_ACK = 1'b0;
                wc = 0;
                pending = 1'b0;
            end
        end
    end

    task automatic refModel(output int e1x, output int e1y, output int e2x, output int e2y, output int ePh);
        int c1x = 0, c1y = 0, c2x = 0, c2y = 0;
        int cur = 0, stall = 0, ph = 0;
        bit fin = 1'b0;
        while (!fin) begin
            int best = 0, bx = 0, by = 0, v;
            for (int cy = 0; cy < 16; cy++) begin
                for (int cx = 0; cx < 16; cx++) begin
                    if (ph % 2 == 0) v = coverCnt(cx, cy, ph != 0, c2x, c2y);
                    else             v = coverCnt(cx, cy, 1'b1, c1x, c1y);
                    if (v > TB_NPTS) v = TB_NPTS;
                    if (v > best) begin best = v; bx = cx; by = cy; end
                end
            end
            if (best > cur) begin
                if (ph % 2 == 0) begin c1x = bx; c1y = by; end
                else             begin c2x = bx; c2y = by; end
                cur = best;
                stall = 0;
            end else begin
                stall++;
            end
            ph++;
            if (stall == 2 || ph == TB_PH_MAX) fin = 1'b1;
        end
        e1x = c1x; e1y = c1y; e2x = c2x; e2y = c2y; ePh = ph;
    endtask

    task automatic waitDone(input int startCyc, output int doneCyc);
        int cyc = startCyc;
        while (DONE !== 1'b1 && cyc < startCyc + 20000) begin
            @(negedge CLK);
            cyc++;
        end
        if (DONE !== 1'b1) checkOutput("doneTimeout", 0, 1);
        doneCyc = cyc;
    endtask

    task automatic afterDone(input string tag);
        @(negedge CLK);
        checkOutput({tag, "_doneLow"}, DONE, 0);
        checkOutput({tag, "_ldEn"}, LD_EN, 1);
        checkOutput({tag, "_ldIdx"}, LD_IDX, 0);
    endtask

    task automatic checkCentres(input string tag, input int c1x, input int c1y, input int c2x, input int c2y);
        checkOutput({tag, "_c1"}, {C1X, C1Y}, 32'((c1x << 4) | c1y));
        checkOutput({tag, "_c2"}, {C2X, C2Y}, 32'((c2x << 4) | c2y));
    endtask

    task automatic applyStimulus();
        int doneCyc, e1x, e1y, e2x, e2y, ePh, guard;

        for (int i = 0; i < TB_NPTS; i++) begin
            if (i < 20) begin ptX[i] = 1 + i % 5;  ptY[i] = 1 + i / 5; end
            else        begin ptX[i] = 10 + (i - 20) % 5; ptY[i] = 9 + (i - 20) / 5; end
        end

        // Reset held for two edges, then the load window and the constant-count pattern.
        evMode = 0; evWait = 0;
        RST = 1'b0;
        @(posedge CLK); @(posedge CLK); @(negedge CLK);
        checkOutput("rstLdEn", LD_EN, 1);
        checkOutput("rstLdIdx", LD_IDX, 0);
        checkOutput("rstEvReq", EV_REQ, 0);
        checkOutput("rstDone", DONE, 0);
        checkOutput("rstCentres", {C1X, C1Y, C2X, C2Y}, 0);
        checkOutput("rstEvFields", {EV_CX, EV_CY, EV_FEN, EV_FX, EV_FY}, 0);
        RST = 1'b1;
        for (int k = 0; k < TB_NPTS; k++) begin
            if (k > 0) @(negedge CLK);
            checkOutput("loadEn", LD_EN, 1);
            checkOutput("loadIdx", LD_IDX, k);
        end
        @(negedge CLK);
        checkOutput("scanLdEn", LD_EN, 0);
        checkOutput("scanReq", EV_REQ, 1);
        checkOutput("scanFirstCand", {EV_CX, EV_CY, EV_FEN}, 0);
        waitDone(41, doneCyc);
        checkOutput("constLatency", doneCyc, 40 + 3 * 257 + 1);
        checkOutput("constEvals", evalCount, 3 * 256);
        checkCentres("const", 0, 0, 0, 0);
        afterDone("const");

        // Coverage-model evaluator with a four-cycle wait.
        evMode = 1; evWait = 4;
        refModel(e1x, e1y, e2x, e2y, ePh);
        waitDone(1, doneCyc);
        checkOutput("modelLatency", doneCyc, 40 + ePh * (256 * 5 + 1) + 1);
        checkOutput("modelEvals", evalCount, ePh * 256);
        checkCentres("model", e1x, e1y, e2x, e2y);
        checkOutput("modelStable", stableErr, 0);
        checkOutput("modelOrder", orderErr, 0);
        afterDone("model");

        // Tie rule, saturating compare and fixed-circle routing.
        evMode = 2; evWait = 1;
        waitDone(1, doneCyc);
        checkOutput("tieLatency", doneCyc, 40 + 4 * 513 + 1);
        checkCentres("tie", 3, 4, 6, 2);
        checkOutput("tieFen0", fenSeen[0], 0);
        checkOutput("tieFen1", fenSeen[1], 1);
        checkOutput("tieFix1", fxSeen[1] * 16 + fySeen[1], 3 * 16 + 4);
        checkOutput("tieFen2", fenSeen[2], 1);
        checkOutput("tieFix2", fxSeen[2] * 16 + fySeen[2], 6 * 16 + 2);
        afterDone("tie");

        // Rising count every phase stops on the phase limit.
        evMode = 3; evWait = 0;
        waitDone(1, doneCyc);
        checkOutput("riseLatency", doneCyc, 40 + 4 * 257 + 1);
        checkOutput("riseEvals", evalCount, 4 * 256);
        checkCentres("rise", 10, 12, 5, 14);
        checkOutput("riseStable", stableErr, 0);
        checkOutput("riseOrder", orderErr, 0);
        afterDone("rise");

        // Reset during a pending request, with ACK asserted throughout reset.
        evMode = 0; evWait = 4;
        guard = 0;
        while (EV_REQ !== 1'b1 && guard < 200) begin
            @(negedge CLK);
            guard++;
        end
        checkOutput("midReqSeen", EV_REQ, 1);
        @(negedge CLK);
        #1;
        RST = 1'b0;
        evForce = 1'b1;
        for (int r = 0; r < 2; r++) begin
            @(negedge CLK);
            checkOutput("midRstReq", EV_REQ, 0);
            checkOutput("midRstLdIdx", LD_IDX, 0);
            checkOutput("midRstLdEn", LD_EN, 1);
            checkOutput("midRstCentres", {C1X, C1Y, C2X, C2Y}, 0);
            checkOutput("midRstDone", DONE, 0);
        end
        RST = 1'b1;
        evForce = 1'b0;
        @(negedge CLK);
        checkOutput("midRelIdx1", LD_IDX, 1);
        @(negedge CLK);
        checkOutput("midRelIdx2", LD_IDX, 2);
        checkOutput("midRelReq", EV_REQ, 0);
    endtask

    initial begin
        applyStimulus();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
